// File: rtl/modexp_pkg.sv
// modexp_pkg: shared types and constants for the modular exponentiation
// controller (modexp_ctrl) and its multiplier handshake engine (mm_issue).
//
// Contents:
//   state_t     - top-level sequencing states
//   phase_t     - ISSUE/WAIT phase of one Montgomery multiply
//   DEF_WIDTH   - default operand / modulus width
//   DEF_EXP_W   - default exponent width
//   DEF_CNT_W   - default bit-index counter width
//   ONE         - the constant operand 1 (zero-extended at the point of use)
package modexp_pkg;

    localparam int DEF_WIDTH = 256;
    localparam int DEF_EXP_W = 256;
    localparam int DEF_CNT_W = 9;

    localparam int unsigned ONE = 1;

    typedef enum logic [3:0] {
        IDLE,
        TO_M,
        TO_X,
        SKIP,
        SQR,
        MUL,
        NEXT,
        FROM,
        RED,
        FIN
    } state_t;

    typedef enum logic {
        ISSUE,
        WAIT
    } phase_t;

endpackage

// File: rtl/modexp_ctrl_mm_issue.sv
// mm_issue: ISSUE/WAIT handshake engine for one Montgomery multiply.
//
// While 'active' is high the engine spends exactly one cycle in ISSUE
// (mm_start_n low), then waits in WAIT until mm_done is seen. The cycle in
// which mm_done is seen during WAIT raises 'cap' for one cycle; the caller
// captures mm_out and moves on. The engine then sits in ISSUE again, so a
// following MM state starts a fresh operation on its first cycle.
// mm_done seen during ISSUE is ignored (it may still be high from the
// previous operation).
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   active      - caller is in a state that needs a multiply
//   mm_done     - multiplier completion level
//   mm_start_n  - multiplier start, active low
//   cap         - one-cycle strobe: mm_out is valid, capture it now
module mm_issue
    import modexp_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mm_done,
    output logic mm_start_n,
    output logic cap
);

    phase_t phase_q;
    phase_t phase_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= ISSUE;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d    = phase_q;
        mm_start_n = 1'b1;
        cap        = 1'b0;
        if (active) begin
            case (phase_q)
                ISSUE: begin
                    mm_start_n = 1'b0;
                    phase_d    = WAIT;
                end
                WAIT: begin
                    if (mm_done) begin
                        cap     = 1'b1;
                        phase_d = ISSUE;
                    end
                end
            endcase
        end else begin
            phase_d = ISSUE;
        end
    end

endmodule

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: sequences an external radix-2 Montgomery multiplier to compute
// result = msg^exp mod mod, using left-to-right square-and-multiply with
// Montgomery-domain entry (via r2 = R^2 mod N) and exit (multiply by 1),
// followed by a single conditional subtraction.
//
// Build option: MODEXP_LZ_SKIP_EN
//   defined   - leading zero bits of the exponent are skipped one per cycle
//               in SKIP before the first square; only latency changes.
//   undefined - every exponent bit is squared.
//
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   start              - one-cycle request, accepted only while busy=0
//   msg, exp, mod, r2  - base M (<N), exponent E, odd modulus N, R^2 mod N
//   busy               - operation in progress
//   done               - one-cycle pulse, result valid
//   result             - M^E mod N, held until overwritten by the next run
//   mm_a, mm_b, mm_n   - multiplier operands / modulus
//   mm_start_n         - multiplier start, active low
//   mm_out, mm_done    - multiplier result (may be +N) and completion level
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// TO_M  | Mb = MM(M, r2)             (base into Montgomery domain)
// TO_X  | X  = MM(1, r2) = R mod N   (accumulator = Montgomery one)
// SKIP  | drop leading zero exponent bits (MODEXP_LZ_SKIP_EN only)
// SQR   | X  = MM(X, X)
// MUL   | X  = MM(X, Mb)             (exponent bit is 1)
// NEXT  | step to the next lower exponent bit, or leave the loop
// FROM  | Y  = MM(X, 1)              (back out of Montgomery domain)
// RED   | result = Y >= N ? Y-N : Y
// FIN   | done pulse
module modexp_ctrl
    import modexp_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXP_WIDTH = DEF_EXP_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     msg,
    input  logic [EXP_WIDTH-1:0] exp,
    input  logic [WIDTH-1:0]     mod,
    input  logic [WIDTH-1:0]     r2,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [WIDTH-1:0]     mm_a,
    output logic [WIDTH-1:0]     mm_b,
    output logic [WIDTH-1:0]     mm_n,
    output logic                 mm_start_n,
    input  logic [WIDTH-1:0]     mm_out,
    input  logic                 mm_done
);

    localparam logic [WIDTH-1:0]     ONE_W   = WIDTH'(ONE);
    localparam logic [EXP_WIDTH-1:0] EXP_LSB = EXP_WIDTH'(1);
    localparam logic [CNT_W-1:0]     IDX_TOP = CNT_W'(EXP_WIDTH - 1);
    localparam logic [CNT_W-1:0]     IDX_ONE = CNT_W'(1);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0]     msg_q;
    logic [EXP_WIDTH-1:0] exp_q;
    logic [WIDTH-1:0]     mod_q;
    logic [WIDTH-1:0]     r2_q;
    logic [WIDTH-1:0]     mb_q;
    logic [WIDTH-1:0]     x_q;
    logic [WIDTH-1:0]     y_q;
    logic [WIDTH-1:0]     result_q;
    logic [CNT_W-1:0]     idx_q;

    logic             accept;
    logic             mm_active;
    logic             cap;
    logic             exp_bit;
    logic             idx_zero;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic [WIDTH:0]   y_ext;
    logic [WIDTH:0]   n_ext;
    logic [WIDTH:0]   red_full;
    logic             red_msb_unused;
    logic [WIDTH-1:0] red_val;

    // Shift-and-mask instead of a variable part-select keeps the index
    // width independent of EXP_WIDTH.
    assign exp_bit  = |(exp_q & (EXP_LSB << idx_q));
    assign idx_zero = (idx_q == '0);

    // busy is low in FIN, so a start coinciding with the done pulse is taken.
    assign accept = start && ((state_q == IDLE) || (state_q == FIN));

    // Final reduction in WIDTH+1 bits: Y may be as large as 2N-1.
    assign y_ext    = {1'b0, y_q};
    assign n_ext    = {1'b0, mod_q};
    assign red_full = (y_ext >= n_ext) ? (y_ext - n_ext) : y_ext;
    assign {red_msb_unused, red_val} = red_full;

    mm_issue u_mm_issue (
        .clk        (clk),
        .rst_n      (rst_n),
        .active     (mm_active),
        .mm_done    (mm_done),
        .mm_start_n (mm_start_n),
        .cap        (cap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mm_active = 1'b0;
        op_a      = '0;
        op_b      = '0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = TO_M;
            end
            TO_M: begin
                mm_active = 1'b1;
                op_a      = msg_q;
                op_b      = r2_q;
                if (cap) state_d = TO_X;
            end
            TO_X: begin
                mm_active = 1'b1;
                op_a      = ONE_W;
                op_b      = r2_q;
`ifdef MODEXP_LZ_SKIP_EN
                if (cap) state_d = SKIP;
`else
                if (cap) state_d = SQR;
`endif
            end
            SKIP: begin
                if (exp_bit)       state_d = SQR;
                else if (idx_zero) state_d = FROM;
            end
            SQR: begin
                mm_active = 1'b1;
                op_a      = x_q;
                op_b      = x_q;
                if (cap) state_d = exp_bit ? MUL : NEXT;
            end
            MUL: begin
                mm_active = 1'b1;
                op_a      = x_q;
                op_b      = mb_q;
                if (cap) state_d = NEXT;
            end
            NEXT: begin
                state_d = idx_zero ? FROM : SQR;
            end
            FROM: begin
                mm_active = 1'b1;
                op_a      = x_q;
                op_b      = ONE_W;
                if (cap) state_d = RED;
            end
            RED: begin
                state_d = FIN;
            end
            FIN: begin
                state_d = accept ? TO_M : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_q    <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            r2_q     <= '0;
            mb_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
        end else begin
            if (accept) begin
                msg_q <= msg;
                exp_q <= exp;
                mod_q <= mod;
                r2_q  <= r2;
            end
            case (state_q)
                TO_M: begin
                    if (cap) mb_q <= mm_out;
                end
                TO_X: begin
                    if (cap) begin
                        x_q   <= mm_out;
                        idx_q <= IDX_TOP;
                    end
                end
                SKIP: begin
                    if (!exp_bit && !idx_zero) idx_q <= idx_q - IDX_ONE;
                end
                SQR, MUL: begin
                    if (cap) x_q <= mm_out;
                end
                NEXT: begin
                    if (!idx_zero) idx_q <= idx_q - IDX_ONE;
                end
                FROM: begin
                    if (cap) y_q <= mm_out;
                end
                RED: begin
                    result_q <= red_val;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state_q != IDLE) && (state_q != FIN);
    assign done   = (state_q == FIN);
    assign result = result_q;
    assign mm_a   = op_a;
    assign mm_b   = op_b;
    assign mm_n   = mm_active ? mod_q : '0;

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl: self-checking bench for modexp_ctrl with a behavioural
// Montgomery multiplier (random latency, randomly returns +N) and a plain
// modular-power reference. Moduli are kept below 2^20 so all reference
// arithmetic fits in 64 bits.
module tb_modexp_ctrl;

    localparam int W  = 256;
    localparam int EW = 256;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  msg;
    logic [EW-1:0] exp;
    logic [W-1:0]  mod;
    logic [W-1:0]  r2;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [W-1:0]  mm_a;
    logic [W-1:0]  mm_b;
    logic [W-1:0]  mm_n;
    logic          mm_start_n;
    logic [W-1:0]  mm_out;
    logic          mm_done;

    int n_tests = 0;
    int n_fail  = 0;

    modexp_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .msg        (msg),
        .exp        (exp),
        .mod        (mod),
        .r2         (r2),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .mm_a       (mm_a),
        .mm_b       (mm_b),
        .mm_n       (mm_n),
        .mm_start_n (mm_start_n),
        .mm_out     (mm_out),
        .mm_done    (mm_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    logic [63:0] nmod_g = 64'd3;
    logic [63:0] rinv_g = 64'd1;

    function automatic logic [63:0] calc_rinv(input logic [63:0] n);
        logic [63:0] inv2 = (n + 64'd1) >> 1;
        logic [63:0] x = 64'd1;
        for (int i = 0; i < W; i++) x = (x * inv2) % n;
        return x;
    endfunction

    function automatic logic [63:0] calc_r2(input logic [63:0] n);
        logic [63:0] x = 64'd1;
        for (int i = 0; i < 2 * W; i++) x = (x * 64'd2) % n;
        return x;
    endfunction

    function automatic logic [63:0] ref_pow(input logic [63:0] m, input logic [EW-1:0] e, input logic [63:0] n);
        logic [63:0] r = 64'd1;
        logic [63:0] b = m % n;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * b) % n;
            b = (b * b) % n;
        end
        return r % n;
    endfunction

    function automatic int exp_ops(input logic [EW-1:0] e);
        int pc = 0;
        int sq;
        int msb = -1;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) begin
                pc++;
                msb = i;
            end
        end
`ifdef MODEXP_LZ_SKIP_EN
        sq = msb + 1;
`else
        sq = EW;
`endif
        return 3 + sq + pc;
    endfunction

    function automatic logic [W-1:0] mm_model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] an = 64'(a % W'(nmod_g));
        logic [63:0] bn = 64'(b % W'(nmod_g));
        logic [63:0] t  = (an * bn) % nmod_g;
        t = (t * rinv_g) % nmod_g;
        if ($urandom_range(0, 1) == 1) t = t + nmod_g;
        return W'(t);
    endfunction

    // ---------------- external multiplier model ----------------
    int          ops_cnt  = 0;
    int          done_cnt = 0;
    int          mmn_err  = 0;
    logic        pend     = 1'b0;
    int          wcnt     = 0;
    logic [W-1:0] lat_a   = '0;
    logic [W-1:0] lat_b   = '0;

    initial begin
        mm_done = 1'b0;
        mm_out  = '0;
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst_n) begin
            pend    = 1'b0;
            mm_done = 1'b0;
        end else if (!mm_start_n) begin
            ops_cnt++;
            if (mm_n !== W'(nmod_g)) mmn_err++;
            lat_a   = mm_a;
            lat_b   = mm_b;
            pend    = 1'b1;
            wcnt    = $urandom_range(0, 3);
            mm_done = 1'b0;
        end else if (pend) begin
            if (wcnt == 0) begin
                mm_out  = mm_model(lat_a, lat_b);
                mm_done = 1'b1;
                pend    = 1'b0;
            end else begin
                wcnt--;
            end
        end
    end

    // ---------------- one exponentiation ----------------
    task automatic run_op(input string tag, input logic [63:0] m, input logic [EW-1:0] e,
                          input logic [63:0] n, input int restart_at, output int ops_o);
        int ops0;
        int done0;
        int err0;
        int cyc = 0;
        logic [63:0] expect_r = ref_pow(m, e, n);
        nmod_g = n;
        rinv_g = calc_rinv(n);
        @(negedge clk);
        ops0  = ops_cnt;
        done0 = done_cnt;
        err0  = mmn_err;
        msg   = W'(m);
        exp   = e;
        mod   = W'(n);
        r2    = W'(calc_r2(n));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val({tag, " busy after start"}, W'(busy), W'(1));
        while (!done && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (cyc == restart_at) begin
                check_val({tag, " busy at restart"}, W'(busy), W'(1));
                msg   = W'((m + 64'd1) % n);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_val({tag, " done seen"}, W'(done), W'(1));
        check_val({tag, " result"}, result, W'(expect_r));
        check_val({tag, " busy low at done"}, W'(busy), W'(0));
        ops_o = ops_cnt - ops0;
        check_val({tag, " mm op count"}, W'(ops_o), W'(exp_ops(e)));
        @(negedge clk);
        check_val({tag, " done single pulse"}, W'(done_cnt - done0), W'(1));
        check_val({tag, " result held"}, result, W'(expect_r));
        check_val({tag, " mm_n operand"}, W'(mmn_err - err0), W'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ops;
        int cyc;
        int done0;
        logic [63:0] n;
        logic [63:0] m;
        logic [EW-1:0] e;

        rst_n = 1'b0;
        start = 1'b0;
        msg   = '0;
        exp   = '0;
        mod   = '0;
        r2    = '0;
        repeat (3) @(negedge clk);
        check_val("reset busy", W'(busy), W'(0));
        check_val("reset done", W'(done), W'(0));
        check_val("reset result", result, W'(0));
        check_val("reset mm_start_n", W'(mm_start_n), W'(1));
        check_val("reset mm_a", mm_a, W'(0));
        check_val("reset mm_b", mm_b, W'(0));
        check_val("reset mm_n", mm_n, W'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op("m2e10", 64'd2, EW'(10), 64'd1009, 0, ops);
        check_val("m2e10 mul ops", W'(ops - exp_ops(EW'(0))), W'(2));

        run_op("e0", 64'd5, EW'(0), 64'd241, 0, ops);
        run_op("m0", 64'd0, EW'(7), 64'd241, 0, ops);

        n = 64'($urandom_range(1000, 1 << 20)) | 64'd1;
        run_op("restart", 64'd123 % n, EW'($urandom) | EW'(32'h0010_0000), n, 50, ops);

        run_op("e5", 64'd3, EW'(5), 64'd1009, 0, ops);

        // reset while the controller waits on the multiplier
        nmod_g = 64'd1009;
        rinv_g = calc_rinv(64'd1009);
        @(negedge clk);
        msg   = W'(7);
        exp   = EW'(32'hdead_beef);
        mod   = W'(1009);
        r2    = W'(calc_r2(64'd1009));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        cyc = 0;
        while (mm_start_n && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_val("abort issue seen", W'(mm_start_n), W'(0));
        @(negedge clk);
        done0 = done_cnt;
        #1 rst_n = 1'b0;
        #1;
        check_val("abort busy", W'(busy), W'(0));
        check_val("abort mm_start_n", W'(mm_start_n), W'(1));
        check_val("abort result", result, W'(0));
        check_val("abort done", W'(done), W'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("abort no done pulse", W'(done_cnt - done0), W'(0));
        run_op("after abort", 64'd7, EW'(32'hdead_beef), 64'd1009, 0, ops);

        for (int i = 0; i < 5; i++) begin
            n = 64'($urandom_range(3, 1 << 20)) | 64'd1;
            m = 64'($urandom) % n;
            e = EW'($urandom);
            if (i == 2) e[EW-1] = 1'b1;
            if (i == 3) e = {8{$urandom}};
            run_op($sformatf("rand%0d", i), m, e, n, 0, ops);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
